// File: rtl/pkg_UART.sv
// -----------------------------------------------------------------------------
// pkg_UART
// Shared definitions for the UART transmitter: FSM state encoding and the
// default timing/payload constants used as module parameter defaults.
// -----------------------------------------------------------------------------
package pkg_UART;

  // 100 MHz system clock / 115200 baud
  localparam int UART_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } tx_state_e;

endpackage

// File: rtl/module_uart_baud_counter.sv
// -----------------------------------------------------------------------------
// module_uart_baud_counter
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps to 0;
// tick_o is high for the one cycle in which the count sits at terminal count.
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset (count -> 0)
//   clear_i - synchronous clear (count -> 0), used while no bit is being timed
//   tick_o  - registered one-cycle pulse coincident with terminal count
// -----------------------------------------------------------------------------
module module_uart_baud_counter
  import pkg_UART::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          tick_r;

  // Next count: clear, wrap at terminal count, otherwise increment
  always_comb begin
    cnt_s = cnt_r;
    if (clear_i) begin
      cnt_s = '0;
    end else if (cnt_r == TERM) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CW'(1);
    end
  end

  // Count register; tick is registered from the next count so it lines up
  // with the cycle in which cnt_r equals TERM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      tick_r <= (cnt_s == TERM);
    end
  end

  assign tick_o = tick_r;

endmodule

// File: rtl/module_uart_tx.sv
// -----------------------------------------------------------------------------
// module_uart_tx
// UART transmitter, 8N1-style framing: start bit (0), DATA_BITS payload bits
// LSB first, one stop bit (1), then a single DONE cycle that asks the control
// register to clear its send bit.
//
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - synchronous active-high reset; aborts any frame at once
//   send_i       - transmit request (control register send bit)
//   tx_data_i    - payload, latched on the cycle the request is accepted
//   tx_o         - registered serial line, idles high
//   busy_o       - high in every state other than IDLE
//   send_clear_o - one-cycle pulse in DONE
//   wr_2_o       - control register write strobe, same cycle as send_clear_o
// Minimum legal values: CLKS_PER_BIT >= 2, DATA_BITS >= 2.
// -----------------------------------------------------------------------------
module module_uart_tx
  import pkg_UART::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 send_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 send_clear_o,
  output logic                 wr_2_o
);

  localparam int            BW       = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_e            state_r;
  tx_state_e            state_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic [BW-1:0]        bit_cnt_r;
  logic [BW-1:0]        bit_cnt_s;
  logic                 tx_r;
  logic                 tx_s;
  logic                 busy_r;
  logic                 busy_s;
  logic                 done_r;
  logic                 done_s;
  logic                 baud_clear_s;
  logic                 baud_tick_s;

  // The bit timer is held at zero outside the timed states so that every
  // frame starts with a full-length start bit.
  assign baud_clear_s = (state_r == IDLE) || (state_r == DONE);

  module_uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(baud_clear_s),
    .tick_o (baud_tick_s)
  );

  // Next-state, shift register and bit counter logic
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    case (state_r)
      IDLE: begin
        if (send_i) begin
          state_s   = START;
          shift_s   = tx_data_i;
          bit_cnt_s = '0;
        end else begin
          state_s   = IDLE;
        end
      end
      START: begin
        if (baud_tick_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (baud_tick_s) begin
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == LAST_BIT) begin
            state_s   = STOP;
            bit_cnt_s = '0;
          end else begin
            state_s   = DATA;
            bit_cnt_s = bit_cnt_r + BW'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (baud_tick_s) begin
          state_s = DONE;
        end else begin
          state_s = STOP;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the outputs can be registered
  // without lagging the state by a cycle
  always_comb begin
    tx_s   = 1'b1;
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      default: tx_s = 1'b1;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign tx_o         = tx_r;
  assign busy_o       = busy_r;
  assign send_clear_o = done_r;
  assign wr_2_o       = done_r;

endmodule
